cpu_phase_clk_gen: RTL

- Parametrised two-phase CPU clock generator for the soft MIPS core; replaces the fixed divide-by-counter toggle in the board top level.
- Produces registered phi1/phi2 with a runtime-selectable divisor and three modes: halt, free-run and debounced single-step.
- Provides a tick pulse and a retired-cycle counter for the VGA debug overlay.

---
 rtl/cpu_phase_clk_gen.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_phase_clk_gen.sv
// Two-phase CPU clock generator: halt / free-run / debounced single-step, selectable divisor.
// Optional non-overlapping phases with DEAD_CYCLES gaps: define CPU_PHASE_NONOVERLAP_EN.
module cpu_phase_clk_gen #(
  parameter int CNT_W       = 24,
  parameter int DIV0        = 10000000,
  parameter int DIV1        = 1000000,
  parameter int DIV2        = 100000,
  parameter int DIV3        = 1,
  parameter int DEB_CYCLES  = 1000000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  input  logic [1:0]  div_sel,
  input  logic        step_btn,
  output logic        phi1,
  output logic        phi2,
  output logic        tick,
  output logic        busy,
  output logic [31:0] cycle_cnt
);

  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
`ifdef CPU_PHASE_NONOVERLAP_EN
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic PHI2_RST = 1'b0;
`else
  localparam logic PHI2_RST = 1'b1;
`endif

  if (DIV0 < 1 || DIV1 < 1 || DIV2 < 1 || DIV3 < 1 ||
      (DIV0 >> CNT_W) != 0 || (DIV1 >> CNT_W) != 0 ||
      (DIV2 >> CNT_W) != 0 || (DIV3 >> CNT_W) != 0 ||
      DEB_CYCLES < 1 || DEAD_CYCLES < 1) begin : g_param_check
    $error("cpu_phase_clk_gen: DIVn must be 1..2^CNT_W-1, DEB_CYCLES/DEAD_CYCLES >= 1");
  end

  typedef enum logic [2:0] {IDLE, HIGH, LOW, DEAD_FALL, DEAD_RISE} state_t;

  logic             sync1_reg, sync2_reg, deb_level_reg, step_req_reg;
  logic [DEB_W-1:0] deb_cnt_reg;
  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg, div_reg, div_sel_val;
  logic             pending_reg, phi1_reg, phi2_reg, tick_reg, busy_reg;
  logic [31:0]      cycle_cnt_reg;
  logic             start_ok, cnt_last, enter_high;

  // The debounced level only flips after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg     <= 1'b0;
      sync2_reg     <= 1'b0;
      deb_level_reg <= 1'b0;
      deb_cnt_reg   <= '0;
      step_req_reg  <= 1'b0;
    end else begin
      sync1_reg    <= step_btn;
      sync2_reg    <= sync1_reg;
      step_req_reg <= 1'b0;
      if (sync2_reg == deb_level_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == DEB_LAST) begin
        deb_level_reg <= sync2_reg;
        deb_cnt_reg   <= '0;
        step_req_reg  <= sync2_reg;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    div_sel_val = CNT_W'(DIV0);
    case (div_sel)
      2'd1:    div_sel_val = CNT_W'(DIV1);
      2'd2:    div_sel_val = CNT_W'(DIV2);
      2'd3:    div_sel_val = CNT_W'(DIV3);
      default: div_sel_val = CNT_W'(DIV0);
    endcase
  end

  assign start_ok = (mode == MODE_RUN) ||
                    ((mode == MODE_STEP) && (step_req_reg || pending_reg));
  assign cnt_last = (cnt_reg == div_reg - 1'b1);

  always_comb begin
    enter_high = 1'b0;
`ifdef CPU_PHASE_NONOVERLAP_EN
    if (state_reg == DEAD_RISE && cnt_reg == DEAD_LAST) enter_high = 1'b1;
`else
    if (state_reg == IDLE && start_ok) enter_high = 1'b1;
    if (state_reg == LOW && cnt_last && mode == MODE_RUN) enter_high = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      div_reg       <= CNT_W'(DIV0);
      pending_reg   <= 1'b0;
      phi1_reg      <= 1'b0;
      phi2_reg      <= PHI2_RST;
      tick_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      cycle_cnt_reg <= '0;
    end else begin
      tick_reg <= 1'b0;
      // One-deep pending request, only meaningful while a step-mode period runs.
      if (mode != MODE_STEP) pending_reg <= 1'b0;
      else if (step_req_reg && state_reg != IDLE) pending_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            pending_reg <= 1'b0;
`ifdef CPU_PHASE_NONOVERLAP_EN
            state_reg <= DEAD_RISE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            phi2_reg  <= 1'b0;
`endif
          end
        end
        HIGH: begin
          if (cnt_last) begin
            cnt_reg  <= '0;
            phi1_reg <= 1'b0;
`ifdef CPU_PHASE_NONOVERLAP_EN
            state_reg <= DEAD_FALL;
`else
            state_reg <= LOW;
            phi2_reg  <= 1'b1;
`endif
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        LOW: begin
          if (cnt_last) begin
            cnt_reg <= '0;
            if (mode != MODE_RUN) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
`ifdef CPU_PHASE_NONOVERLAP_EN
            else begin
              state_reg <= DEAD_RISE;
              phi2_reg  <= 1'b0;
            end
`endif
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`ifdef CPU_PHASE_NONOVERLAP_EN
        DEAD_FALL: begin
          if (cnt_reg == DEAD_LAST) begin
            cnt_reg   <= '0;
            state_reg <= LOW;
            phi2_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DEAD_RISE: begin
          if (cnt_reg != DEAD_LAST) cnt_reg <= cnt_reg + 1'b1;
        end
`endif
        default: state_reg <= IDLE;
      endcase

      // Common HIGH entry: the divisor is sampled only here, so div_sel never cuts a phase short.
      if (enter_high) begin
        state_reg     <= HIGH;
        cnt_reg       <= '0;
        div_reg       <= div_sel_val;
        tick_reg      <= 1'b1;
        cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
        phi1_reg      <= 1'b1;
        phi2_reg      <= 1'b0;
        busy_reg      <= 1'b1;
      end
    end
  end

  assign phi1      = phi1_reg;
  assign phi2      = phi2_reg;
  assign tick      = tick_reg;
  assign busy      = busy_reg;
  assign cycle_cnt = cycle_cnt_reg;

endmodule
